// File: rtl/rk16_pkg.sv
// Shared definitions for the rk16 sequencer: state encoding, one-hot stage codes
// and the default memory-wait limit.
package rk16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] STAGE_NONE = 4'b0000;
    localparam logic [3:0] STAGE_F    = 4'b0001;
    localparam logic [3:0] STAGE_D    = 4'b0010;
    localparam logic [3:0] STAGE_E    = 4'b0100;
    localparam logic [3:0] STAGE_W    = 4'b1000;

    localparam int unsigned MEM_TO_DEFAULT = 15;

    // EXEC and MEM share the execute stage code; IDLE and HALT show no stage.
    function automatic logic [3:0] stage_of(input state_t s);
        logic [3:0] code;
        case (s)
            ST_FETCH:  code = STAGE_F;
            ST_DECODE: code = STAGE_D;
            ST_EXEC:   code = STAGE_E;
            ST_MEM:    code = STAGE_E;
            ST_WB:     code = STAGE_W;
            default:   code = STAGE_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback
// control with a bounded memory wait, HALT and interrupt entry at WB or HALT.
module seq_ctrl
    import rk16_pkg::*;
#(
    parameter int unsigned MEM_TO = MEM_TO_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        op_mem,
    input  logic        op_store,
    input  logic        op_wb,
    input  logic        op_halt,
    input  logic        irq,
    input  logic        mem_ack,
    output logic [3:0]  stage,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_intr,
    output logic        rf_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        halted,
    output logic        bus_err,
    output logic [15:0] instret
);

    // Counter value seen on the last permitted MEM cycle.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_TO - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic        timeout_s;
    logic        pc_intr_s;

    logic        op_mem_r;
    logic        op_store_r;
    logic        op_wb_r;
    logic        op_halt_r;
    logic [3:0]  wait_cnt_r;

    logic [3:0]  stage_r;
    logic        ir_en_r;
    logic        pc_en_r;
    logic        rf_we_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic        halted_r;
    logic        bus_err_r;
    logic [15:0] instret_r;

    // Next-state decode plus the interrupt-taken and timeout strobes.
    always_comb begin
        next_state_s = state_r;
        timeout_s    = 1'b0;
        pc_intr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                next_state_s = ST_DECODE;
            end
            ST_DECODE: begin
                if (op_halt) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_mem_r) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_MEM: begin
                // An acknowledge on the final wait cycle still completes the access.
                if (mem_ack) begin
                    next_state_s = ST_WB;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB: begin
                pc_intr_s = irq;
                if (run || irq) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (irq) begin
                    pc_intr_s    = 1'b1;
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the decoded operation while in DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_mem_r   <= 1'b0;
            op_store_r <= 1'b0;
            op_wb_r    <= 1'b0;
            op_halt_r  <= 1'b0;
        end else if (state_r == ST_DECODE) begin
            op_mem_r   <= op_mem;
            op_store_r <= op_store;
            op_wb_r    <= op_wb;
            op_halt_r  <= op_halt;
        end else begin
            op_mem_r   <= op_mem_r;
            op_store_r <= op_store_r;
            op_wb_r    <= op_wb_r;
            op_halt_r  <= op_halt_r;
        end
    end

    // Memory wait counter; held at zero outside MEM so every entry starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
        end else if (state_r == ST_MEM) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // Outputs are registered from the next state so they line up with state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_r   <= STAGE_NONE;
            ir_en_r   <= 1'b0;
            pc_en_r   <= 1'b0;
            rf_we_r   <= 1'b0;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            halted_r  <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            stage_r   <= stage_of(next_state_s);
            ir_en_r   <= (next_state_s == ST_FETCH);
            pc_en_r   <= (next_state_s == ST_WB);
            rf_we_r   <= (next_state_s == ST_WB) && op_wb_r;
            mem_req_r <= (next_state_s == ST_MEM);
            mem_we_r  <= (next_state_s == ST_MEM) && op_store_r;
            halted_r  <= (next_state_s == ST_HALT);
            bus_err_r <= timeout_s;
        end
    end

    // Retired-instruction counter, advanced once per WB cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= 16'd0;
        end else if (state_r == ST_WB) begin
            instret_r <= instret_r + 16'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    // Interrupt vector selection must accompany the pc_en of the same cycle,
    // so the interrupt path is decoded directly from state and irq.
    assign stage   = stage_r;
    assign ir_en   = ir_en_r;
    assign pc_en   = pc_en_r | pc_intr_s;
    assign pc_intr = pc_intr_s;
    assign rf_we   = rf_we_r;
    assign mem_req = mem_req_r;
    assign mem_we  = mem_we_r;
    assign halted  = halted_r;
    assign bus_err = bus_err_r;
    assign instret = instret_r;

endmodule
